mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arb_grant.sv | 35 +++
 rtl/mem_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: port identities and
// default bus widths.
package mem_arbiter_pkg;

   typedef enum logic {
      PORT_FETCH = 1'b0,
      PORT_DATA  = 1'b1
   } port_id_t;

   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_arb_grant.sv
// Fixed-priority grant (data first) with a starvation counter that hands the
// bus to the fetch port after STARVE_LIMIT consecutive data wins.
module mem_arb_grant #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_ren,
   input  logic d_req,
   output logic i_gnt,
   output logic d_gnt
);

   localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;

   // Grants are suppressed while reset is held so the bus stays idle.
   always_comb begin
      d_gnt = rst && d_req && (!i_ren || (starve_cnt != LIMIT));
      i_gnt = rst && i_ren && !d_gnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (!i_ren || i_gnt) begin
         starve_cnt <= '0;
      end else if (d_gnt && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory bus: muxes the granted
// payload onto the bus and steers the one-cycle-later read response.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW           = DEF_AW,
   parameter int DW           = DEF_DW,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_ren,
   input  logic [AW-1:0]   i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_ren,
   input  logic            d_wen,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   input  logic [DW/8-1:0] d_bytemask,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            bus_ren,
   output logic            bus_wen,
   output logic [AW-1:0]   bus_raddr,
   output logic [AW-1:0]   bus_waddr,
   output logic [DW-1:0]   bus_wdata,
   output logic [DW/8-1:0] bus_bytemask,
   input  logic [DW-1:0]   bus_rdata
);

   logic     d_rd;
   logic     d_wr;
   logic     rsp_pending;
   port_id_t rsp_owner;

   mem_arb_grant #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_grant (
      .clk  (clk),
      .rst  (rst),
      .i_ren(i_ren),
      .d_req(d_ren | d_wen),
      .i_gnt(i_gnt),
      .d_gnt(d_gnt)
   );

   // A simultaneous read+write strobe from the data port is taken as a read.
   always_comb begin
      d_rd         = d_gnt && d_ren;
      d_wr         = d_gnt && d_wen && !d_ren;
      bus_ren      = i_gnt || d_rd;
      bus_wen      = d_wr;
      bus_raddr    = '0;
      bus_waddr    = '0;
      bus_wdata    = '0;
      bus_bytemask = '0;
      if (i_gnt) begin
         bus_raddr = i_addr;
      end else if (d_rd) begin
         bus_raddr = d_addr;
      end
      if (d_wr) begin
         bus_waddr    = d_addr;
         bus_wdata    = d_wdata;
         bus_bytemask = d_bytemask;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_pending <= 1'b0;
         rsp_owner   <= PORT_FETCH;
      end else begin
         rsp_pending <= bus_ren;
         rsp_owner   <= d_gnt ? PORT_DATA : PORT_FETCH;
      end
   end

   // Read data is shared by both ports; only rvalid identifies the owner.
   always_comb begin
      i_rvalid = rsp_pending && (rsp_owner == PORT_FETCH);
      d_rvalid = rsp_pending && (rsp_owner == PORT_DATA);
      i_rdata  = rst ? bus_rdata : '0;
      d_rdata  = rst ? bus_rdata : '0;
   end

endmodule
